srff_monitor: RTL
=================

# srff_monitor

Passive response checker for the SR flip-flop: samples the `s`/`r` commands driven into the flop, keeps a reference model of the expected `q`, and reads back `q`/`q_bar` one cycle later. It flags mismatches and forbidden `s=r=1` commands, and keeps saturating statistics. It sits beside the flop in benches and in on-chip self-test wrappers. It drives nothing into the flop.

## Interface
- `CNT_W`, default 8: width of the saturating error and forbidden-command counters.
- `CYC_W`, default 16: width of the free-running cycle counter and the first-error timestamp.

- `clk`  in  1  single clock; the flop under check shares it. All sampling is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s`  in  1  set command seen by the flop.
- `r`  in  1  reset command seen by the flop.
- `q`  in  1  flop output being checked.
- `q_bar`  in  1  flop complementary output being checked.
- `exp_q`  out  1  model's expected `q`.
- `tracking`  out  1  high when the state is TRACK.
- `mismatch`  out  1  one-cycle pulse when a check fails.
- `err_sticky`  out  1  set on the first mismatch; held until `rst`.
- `err_count`  out  CNT_W  count of mismatches; saturating.
- `forbid_count`  out  CNT_W  count of `s=r=1` samples; saturating.
- `first_err_cyc`  out  CYC_W  value of `cyc` at the first mismatch.
- `cyc`  out  CYC_W  free-running cycle counter; wraps.

## Operation
- FSM states:
  - UNKNOWN: the reset state; expected value is not yet defined.
  - TRACK: `exp_q` is valid.
  - UNDEF: entered after a forbidden command.
- Transitions, evaluated on `{s,r}` at every edge with `rst`=0:
  - UNKNOWN or UNDEF:
    - 10: go to TRACK, `exp_q`<=1.
    - 01: go to TRACK, `exp_q`<=0.
    - 00: stay.
    - 11: stay, and increment `forbid_count`.
  - TRACK:
    - 00: hold `exp_q`.
    - 01: `exp_q`<=0.
    - 10: `exp_q`<=1.
    - 11: go to UNDEF, increment `forbid_count`, and leave `exp_q` unchanged.
- Check enable: `chk_en`<=1 exactly when the next state is TRACK, else 0.
- Check rule: at an edge where `chk_en`=1, `mismatch`<=1 if `q`!=`exp_q` or `q_bar`!=~`q`. Otherwise `mismatch`<=0.
- No checks are made in UNKNOWN or UNDEF. This includes the complement check, because flop outputs may be X there.
- On `mismatch`:
  - `err_count` increments, saturating at 2^CNT_W-1 with no wrap.
  - If `err_sticky` was 0, `first_err_cyc`<=`cyc` sampled on the same edge, and `err_sticky`<=1.
- `forbid_count` saturates at 2^CNT_W-1.
- `cyc` increments every non-reset cycle and wraps from 2^CYC_W-1 to 0.

## Timing
- Reset values: state UNKNOWN, `exp_q`=0, `tracking`=0, `chk_en`=0, `mismatch`=0, `err_sticky`=0, `err_count`=0, `forbid_count`=0, `first_err_cyc`=0, `cyc`=0.
- `rst` mid-operation: all registers return to the reset values on that edge. There is no carry-over of the model.
- Latency: a command sampled at edge k updates `exp_q` at edge k. The flop's response is then sampled and compared at edge k+1. `mismatch` is visible from k+1 until k+2.
- A new command and a check occur on the same edge. The check uses the `exp_q` from the previous edge; the update uses the current `{s,r}`.
- Counter saturation and a new event on the same edge: the counter stays at its maximum. `mismatch` still pulses.
- 11 while in TRACK: the check at that edge still uses the old `exp_q`. The next edge does no check.

## Structure
- A shared package `srff_pkg` holds:
  - the FSM state enum (UNKNOWN=2'd0, TRACK=2'd1, UNDEF=2'd2);
  - the command constants CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_FORBID=2'b11.
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `rst`, `inc`; output `count`), is instantiated twice: once for `err_count`, once for `forbid_count`.

## Test plan
- `rst`=1 for 2 cycles, then `{s,r}`=00 for 3 cycles:
  - all outputs stay at their reset values except `cyc`, which reaches 3;
  - `tracking`=0, and no mismatch occurs even with `q`=X.
- Commands 10, 00, 01, 00 with a correct flop:
  - `tracking`=1 from the first edge;
  - `exp_q` follows 1, 1, 0, 0;
  - `err_count`=0.
- With the model tracking `exp_q`=1, force `q`=0 at the next check edge:
  - one-cycle `mismatch`;
  - `err_sticky`=1, `err_count`=1;
  - `first_err_cyc` equals the `cyc` value at that edge;
  - a second forced error gives `err_count`=2 and leaves `first_err_cyc` unchanged.
- Command 11 while tracking:
  - `forbid_count`=1, state UNDEF, `tracking`=0;
  - `q`/`q_bar` garbage causes no mismatch;
  - a following 01 returns to TRACK with `exp_q`=0.
- With `q`=`q_bar`=1 while tracking: mismatch from the complement check.
- With `CNT_W`=2, inject 5 errors: `err_count` holds at 3.
- Assert `rst` in the middle of a run: the next cycle shows all reset values and state UNKNOWN.

Source files
------------

// File: rtl/srff_pkg.sv
// Shared types and command encodings for the SR flip-flop monitor.
package srff_pkg;

    // Model state: whether the expected q is known.
    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        TRACK   = 2'd1,
        UNDEF   = 2'd2
    } state_e;

    // {s,r} command encodings.
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RST    = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_FORBID = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment unless already at the maximum; no wrap.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/srff_monitor.sv
// Passive SR flip-flop checker: models expected q from s/r, compares the
// flop's q/q_bar one cycle later, and keeps error statistics.
module srff_monitor
    import srff_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             tracking,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] forbid_count,
    output logic [CYC_W-1:0] first_err_cyc,
    output logic [CYC_W-1:0] cyc
);

    state_e     state, state_nxt;
    logic       exp_q_nxt;
    logic       forbid_inc;
    logic       chk_en;
    logic       mis_nxt;
    logic [1:0] cmd;

    assign cmd      = {s, r};
    assign tracking = (state == TRACK);

    // State register for the reference model.
    always_ff @(posedge clk) begin
        if (rst)
            state <= UNKNOWN;
        else
            state <= state_nxt;
    end

    // Next-state and expected-value update from the current command.
    always_comb begin
        state_nxt  = state;
        exp_q_nxt  = exp_q;
        forbid_inc = 1'b0;
        case (state)
            TRACK: begin
                case (cmd)
                    CMD_RST:    exp_q_nxt = 1'b0;
                    CMD_SET:    exp_q_nxt = 1'b1;
                    CMD_FORBID: begin
                        state_nxt  = UNDEF;
                        forbid_inc = 1'b1;
                    end
                    default:    ;
                endcase
            end
            default: begin
                // UNKNOWN and UNDEF both wait for a defining command.
                case (cmd)
                    CMD_SET: begin
                        state_nxt = TRACK;
                        exp_q_nxt = 1'b1;
                    end
                    CMD_RST: begin
                        state_nxt = TRACK;
                        exp_q_nxt = 1'b0;
                    end
                    CMD_FORBID: forbid_inc = 1'b1;
                    default:    ;
                endcase
            end
        endcase
    end

    // The check compares against the expectation registered last edge;
    // chk_en gates it off whenever the flop outputs may be undefined.
    assign mis_nxt = chk_en && ((q != exp_q) || (q_bar != ~q));

    // Model value, check enable, mismatch pulse, cycle count and first-error stamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q         <= 1'b0;
            chk_en        <= 1'b0;
            mismatch      <= 1'b0;
            err_sticky    <= 1'b0;
            first_err_cyc <= '0;
            cyc           <= '0;
        end else begin
            exp_q    <= exp_q_nxt;
            chk_en   <= (state_nxt == TRACK);
            mismatch <= mis_nxt;
            cyc      <= cyc + 1'b1;
            if (mis_nxt && !err_sticky) begin
                err_sticky    <= 1'b1;
                first_err_cyc <= cyc;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mis_nxt),
        .count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_forbid_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (forbid_inc),
        .count (forbid_count)
    );

endmodule
